// File: rtl/mem_req_responder_pkg.sv
// Shared definitions for the MEM-stage load/store responder.
// Holds the FSM state encoding and the default access timeout.
package mem_req_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_req_responder_timeout_ctr.sv
// Access timeout counter for the memory responder.
// Ports: clk, rst (sync, active-low), clear, enable in; hit out
// (high while the count equals TIMEOUT-1).
module timeout_ctr #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    logic [CNT_W-1:0] cnt;

    // Clear wins over enable so an exiting access never carries a count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign hit = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_req_responder.sv
// MEM-stage responder: turns EX/MEM load/store requests into a
// multi-cycle memory port access and stalls the pipeline meanwhile.
// Ports: clk, rst (sync, active-low); req_rd/req_wr/req_addr/req_wdata
// from the pipeline; mem_stall, rd_data, done, err back to it;
// mem_req/mem_wr/mem_addr/mem_wdata out and mem_ack/mem_rdata in
// on the memory port.
module mem_req_responder
    import mem_req_responder_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        mem_stall,
    output logic [15:0] rd_data,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);

    state_t      state;
    logic [15:0] cap_addr;
    logic [15:0] cap_wdata;
    logic        cap_wr;
    logic        req_any;
    logic        bad_req;
    logic        in_issue;
    logic        hit;
    logic        ctr_clear;

    assign req_any  = req_rd | req_wr;
    assign bad_req  = req_addr[0] | (req_rd & req_wr);
    assign in_issue = (state == ST_ISSUE);

    // The stall must rise in the very cycle a request appears,
    // before the pipeline registers can advance past it.
    assign mem_stall = in_issue | ((state == ST_IDLE) & req_any);

    assign mem_addr  = cap_addr;
    assign mem_wdata = cap_wdata;

    // Counter runs only across consecutive un-acked ISSUE cycles.
    assign ctr_clear = ~in_issue | mem_ack | hit;

    timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_ctr (
        .clk    (clk),
        .rst    (rst),
        .clear  (ctr_clear),
        .enable (in_issue),
        .hit    (hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wr    <= 1'b0;
            rd_data   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cap_wr    <= req_wr;
                        if (bad_req) begin
                            state   <= ST_ERR;
                            done    <= 1'b1;
                            err     <= 1'b1;
                            rd_data <= '0;
                        end else begin
                            state   <= ST_ISSUE;
                            mem_req <= 1'b1;
                            mem_wr  <= req_wr;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem_ack) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        mem_req <= 1'b0;
                        mem_wr  <= 1'b0;
                        if (!cap_wr) begin
                            rd_data <= mem_rdata;
                        end
                    end else if (hit) begin
                        state   <= ST_ERR;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        rd_data <= '0;
                        mem_req <= 1'b0;
                        mem_wr  <= 1'b0;
                    end
                end
                // Response cycles always return to IDLE; the request
                // still visible here belongs to this finished access.
                ST_DONE,
                ST_ERR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_responder.sv
// Self-checking bench for mem_req_responder: transaction-level model
// plus directed scenarios and a randomized request/ack phase.
module tb_mem_req_responder;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        mem_stall;
    logic [15:0] rd_data;
    logic        done;
    logic        err;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_req_responder #(
        .TIMEOUT (TO),
        .CNT_W   (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .mem_stall (mem_stall),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory port: ack after ack_delay ISSUE cycles (-1 = never).
    int          ack_delay = 0;
    bit          noise = 0;
    bit          use_fixed = 0;
    logic [15:0] fixed_rdata = '0;
    int          issue_cyc = 0;

    always @(posedge clk) begin
        #1;
        if (mem_req === 1'b1) begin
            mem_ack = (ack_delay >= 0 && issue_cyc == ack_delay);
            mem_rdata = use_fixed ? fixed_rdata : 16'($urandom);
            issue_cyc++;
        end else begin
            issue_cyc = 0;
            mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = 16'($urandom);
        end
    end

    // Transaction-level model: one access in flight, then a response.
    bit          started = 0;
    bit          m_busy = 0;
    int          m_resp = 0;
    int          m_wait = 0;
    logic        m_wr = 1'b0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    logic [15:0] m_rd = '0;
    bit          exp_stall;

    // Observed memory accesses.
    int          cyc = 0;
    bit          prev_req = 0;
    int          cur_len = 0;
    int          last_len = 0;
    int          done_cnt = 0;
    logic [15:0] acc_addr[$];
    logic        acc_wr_q[$];
    logic [15:0] acc_wd_q[$];
    int          acc_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (started) begin
            exp_stall = m_busy || (m_resp == 0 && (req_rd || req_wr));
            check("stall", 32'(mem_stall), 32'(exp_stall));
            check("done", 32'(done), 32'(m_resp != 0));
            check("err", 32'(err), 32'(m_resp == 2));
            check("mem_req", 32'(mem_req), 32'(m_busy));
            check("mem_wr", 32'(mem_wr), 32'(m_busy && m_wr));
            check("rd_data", 32'(rd_data), 32'(m_rd));
            if (m_busy) begin
                check("mem_addr", 32'(mem_addr), 32'(m_addr));
                check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            end
        end
        if (mem_req === 1'b1) begin
            if (!prev_req) begin
                acc_addr.push_back(mem_addr);
                acc_wr_q.push_back(mem_wr);
                acc_wd_q.push_back(mem_wdata);
                acc_cyc.push_back(cyc);
                cur_len = 0;
            end
            cur_len++;
        end else if (prev_req) begin
            last_len = cur_len;
        end
        prev_req = (mem_req === 1'b1);
        if (done === 1'b1) done_cnt++;
        if (rst !== 1'b1) begin
            m_busy = 0;
            m_resp = 0;
            m_rd = '0;
            m_wait = 0;
            started = 1;
        end else if (started) begin
            if (m_resp != 0) begin
                m_resp = 0;
            end else if (m_busy) begin
                if (mem_ack === 1'b1) begin
                    m_busy = 0;
                    m_resp = 1;
                    if (!m_wr) m_rd = mem_rdata;
                end else begin
                    m_wait++;
                    if (m_wait == TO) begin
                        m_busy = 0;
                        m_resp = 2;
                        m_rd = '0;
                    end
                end
            end else if (req_rd || req_wr) begin
                m_addr = req_addr;
                m_wdata = req_wdata;
                m_wr = req_wr;
                if (req_addr[0] || (req_rd && req_wr)) begin
                    m_resp = 2;
                    m_rd = '0;
                end else begin
                    m_busy = 1;
                    m_wait = 0;
                end
            end
        end
    end

    // Present one request and hold it until the done cycle has passed.
    task automatic do_req(input logic rd, input logic wr,
                          input logic [15:0] a, input logic [15:0] wd,
                          input bit scr, output int st,
                          output logic e, output logic [15:0] r);
        bit fin;
        req_rd = rd;
        req_wr = wr;
        req_addr = a;
        req_wdata = wd;
        st = 0;
        e = 1'b0;
        r = '0;
        fin = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mem_stall === 1'b1) st++;
            if (done === 1'b1) begin
                fin = 1;
                e = err;
                r = rd_data;
            end
            @(posedge clk);
            #1;
            if (fin) break;
            if (scr) begin
                req_addr = 16'($urandom);
                req_wdata = 16'($urandom);
            end
        end
        if (!fin) check("req_no_done", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        req_rd = 1'b0;
        req_wr = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          st;
        logic        e;
        logic [15:0] r;
        int          n0;
        int          d0;
        logic [15:0] a;
        logic        rd;
        logic        wr;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_stall", 32'(mem_stall), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // Load, ack on the third ISSUE cycle.
        use_fixed = 1;
        fixed_rdata = 16'hBEEF;
        ack_delay = 2;
        n0 = acc_addr.size();
        do_req(1'b1, 1'b0, 16'h0010, 16'h5555, 0, st, e, r);
        idle(1);
        check("t1_stall", 32'(st), 32'd4);
        check("t1_err", 32'(e), 32'd0);
        check("t1_rd", 32'(r), 32'h0000BEEF);
        check("t1_len", 32'(last_len), 32'd3);
        check("t1_addr", 32'(acc_addr[n0]), 32'h10);
        check("t1_wr", 32'(acc_wr_q[n0]), 32'd0);

        // Store, ack in the first ISSUE cycle.
        ack_delay = 0;
        n0 = acc_addr.size();
        do_req(1'b0, 1'b1, 16'h0020, 16'h1234, 0, st, e, r);
        idle(1);
        check("t2_stall", 32'(st), 32'd2);
        check("t2_err", 32'(e), 32'd0);
        check("t2_rd_kept", 32'(r), 32'h0000BEEF);
        check("t2_len", 32'(last_len), 32'd1);
        check("t2_wr", 32'(acc_wr_q[n0]), 32'd1);
        check("t2_wdata", 32'(acc_wd_q[n0]), 32'h1234);

        // Unaligned load and conflicting rd+wr.
        n0 = acc_addr.size();
        do_req(1'b1, 1'b0, 16'h0021, 16'h0000, 0, st, e, r);
        check("t3a_stall", 32'(st), 32'd1);
        check("t3a_err", 32'(e), 32'd1);
        check("t3a_rd", 32'(r), 32'd0);
        do_req(1'b1, 1'b1, 16'h0020, 16'h7777, 0, st, e, r);
        idle(1);
        check("t3b_stall", 32'(st), 32'd1);
        check("t3b_err", 32'(e), 32'd1);
        check("t3b_noacc", 32'(acc_addr.size()), 32'(n0));

        // Timeout with no ack.
        ack_delay = -1;
        do_req(1'b1, 1'b0, 16'h0030, 16'h0000, 0, st, e, r);
        idle(1);
        check("t4_len", 32'(last_len), 32'd16);
        check("t4_err", 32'(e), 32'd1);
        check("t4_stall", 32'(st), 32'd17);

        // Ack on the last allowed ISSUE cycle completes normally.
        ack_delay = TO - 1;
        fixed_rdata = 16'hA5A4;
        do_req(1'b1, 1'b0, 16'h0032, 16'h0000, 0, st, e, r);
        idle(1);
        check("t4b_len", 32'(last_len), 32'd16);
        check("t4b_err", 32'(e), 32'd0);
        check("t4b_rd", 32'(r), 32'h0000A5A4);

        // Back-to-back loads.
        ack_delay = 1;
        n0 = acc_addr.size();
        do_req(1'b1, 1'b0, 16'h0002, 16'h0000, 0, st, e, r);
        do_req(1'b1, 1'b0, 16'h0004, 16'h0000, 0, st, e, r);
        idle(2);
        check("t5_count", 32'(acc_addr.size() - n0), 32'd2);
        check("t5_addr0", 32'(acc_addr[n0]), 32'h2);
        check("t5_addr1", 32'(acc_addr[n0 + 1]), 32'h4);
        check("t5_gap", 32'(acc_cyc[n0 + 1] - acc_cyc[n0]), 32'd4);
        check("t5_stall2", 32'(st), 32'd3);

        // Reset in the second ISSUE cycle.
        ack_delay = -1;
        req_rd = 1'b1;
        req_addr = 16'h0040;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_rd = 1'b0;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t6_req", 32'(mem_req), 32'd0);
        check("t6_stall", 32'(mem_stall), 32'd0);
        check("t6_rd", 32'(rd_data), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        n0 = acc_addr.size();
        @(posedge clk);
        #1;
        rst = 1'b1;
        noise = 1;
        idle(6);
        check("t6_nodone", 32'(done_cnt), 32'(d0));
        check("t6_noacc", 32'(acc_addr.size()), 32'(n0));

        // Randomized phase.
        use_fixed = 0;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                idle($urandom_range(1, 3));
            end else begin
                a = 16'($urandom) & 16'hFFFE;
                if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
                rd = 1'($urandom_range(0, 1));
                wr = ~rd;
                if ($urandom_range(0, 9) == 0) begin
                    rd = 1'b1;
                    wr = 1'b1;
                end
                case ($urandom_range(0, 9))
                    0: ack_delay = -1;
                    1: ack_delay = $urandom_range(13, 15);
                    default: ack_delay = $urandom_range(0, 4);
                endcase
                do_req(rd, wr, a, 16'($urandom),
                       1'($urandom_range(0, 1)), st, e, r);
                if ($urandom_range(0, 1) == 1) idle(1);
            end
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
